// File: rtl/sdr_port_arbiter_pkg.sv
// sdr_port_arbiter_pkg: shared state/owner encodings and default sizing for the SDRAM port arbiter
package sdr_port_arbiter_pkg;
  localparam int AW_DEF = 18;
  localparam int LAT_DEF = 3;
  localparam int STARVE_LIM_DEF = 4;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return &v ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/sdr_port_arbiter_arb_pick.sv
// sdr_port_arbiter_arb_pick: IDLE grant decision (CPU priority with DMA anti-starvation) and starve counter
module sdr_port_arbiter_arb_pick
  import sdr_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic clk_25mhz,
  input  logic reset,
  input  logic pick_en,
  input  logic cpu_cand,
  input  logic dma_req,
  output logic grant,
  output logic win
);
  localparam int SW = $clog2(STARVE_LIM + 1);
  logic [SW-1:0] starve_q, starve_d;
  always_comb begin
    grant = pick_en & (cpu_cand | dma_req);
    win = dma_req & (~cpu_cand | (starve_q >= SW'(STARVE_LIM)));
    starve_d = (~dma_req | (grant & win)) ? '0 :
               (grant & (starve_q < SW'(STARVE_LIM))) ? starve_q + 1'b1 : starve_q;
  end
  always_ff @(posedge clk_25mhz) begin
    if (reset) starve_q <= '0;
    else starve_q <= starve_d;
  end
endmodule

// File: rtl/sdr_port_arbiter.sv
// sdr_port_arbiter: shares one SDRAM port between the CPU and a DMA master, stalling the CPU via READY.
// Optional grant/wait statistics ports are built when ARB_STATS_EN is defined.
module sdr_port_arbiter
  import sdr_port_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int LAT = LAT_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic          clk_25mhz,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [15:0]   cpu_wdata,
  output logic [15:0]   cpu_rdata,
  output logic          cpu_rdy,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [15:0]   dma_wdata,
  output logic [15:0]   dma_rdata,
  output logic          dma_ack,
  output logic          sdr_csn,
  output logic          sdr_as,
  output logic          sdr_nwr,
  output logic [AW-1:0] sdr_ad,
  output logic [15:0]   sdr_din,
  input  logic [15:0]   sdr_dout
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]   stat_cpu,
  output logic [15:0]   stat_dma,
  output logic [7:0]    stat_maxwait
`endif
);
  localparam int CW = $clog2(LAT + 1);
  state_e state_q, state_d;
  owner_e own_q, own_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pend_q, pend_d, pwe_q, pwe_d, nwr_q, nwr_d;
  logic [AW-1:0] paddr_q, paddr_d, ad_q, ad_d;
  logic [15:0] pwd_q, pwd_d, din_q, din_d, crd_q, crd_d, drd_q, drd_d;
  logic grant, win, take, cpu_done, cap;
  assign take = cpu_req & ~pend_q;
  assign cpu_done = state_q == S_DONE && own_q == OWN_CPU;
  assign cap = state_q == S_WAIT && cnt_q == '0;
  sdr_port_arbiter_arb_pick #(.STARVE_LIM(STARVE_LIM)) u_pick (
    .clk_25mhz(clk_25mhz),
    .reset(reset),
    .pick_en(state_q == S_IDLE),
    .cpu_cand(cpu_req | pend_q),
    .dma_req(dma_req),
    .grant(grant),
    .win(win)
  );
  // A CPU grant in the same cycle as its cpu_req reads the slot's next value.
  always_comb begin
    state_d = state_q;
    own_d = own_q;
    cnt_d = cnt_q;
    pend_d = cpu_done ? 1'b0 : pend_q | cpu_req;
    pwe_d = take ? cpu_we : pwe_q;
    paddr_d = take ? cpu_addr : paddr_q;
    pwd_d = take ? cpu_wdata : pwd_q;
    nwr_d = nwr_q;
    ad_d = ad_q;
    din_d = din_q;
    crd_d = cap && own_q == OWN_CPU ? sdr_dout : crd_q;
    drd_d = cap && own_q == OWN_DMA ? sdr_dout : drd_q;
    case (state_q)
      S_IDLE: if (grant) begin
        state_d = S_ACC;
        own_d = owner_e'(win);
        nwr_d = win ? ~dma_we : ~pwe_d;
        ad_d = win ? dma_addr : paddr_d;
        din_d = win ? dma_wdata : pwd_d;
      end
      S_ACC: begin
        state_d = S_WAIT;
        cnt_d = CW'(LAT - 1);
      end
      S_WAIT: begin
        state_d = cap ? S_DONE : S_WAIT;
        cnt_d = cap ? cnt_q : cnt_q - 1'b1;
      end
      S_DONE: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      state_q <= S_IDLE;
      own_q <= OWN_CPU;
      cnt_q <= '0;
      pend_q <= 1'b0;
      pwe_q <= 1'b0;
      nwr_q <= 1'b1;
      paddr_q <= '0;
      ad_q <= '0;
      pwd_q <= '0;
      din_q <= '0;
      crd_q <= '0;
      drd_q <= '0;
    end else begin
      state_q <= state_d;
      own_q <= own_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      pwe_q <= pwe_d;
      nwr_q <= nwr_d;
      paddr_q <= paddr_d;
      ad_q <= ad_d;
      pwd_q <= pwd_d;
      din_q <= din_d;
      crd_q <= crd_d;
      drd_q <= drd_d;
    end
  end
  assign sdr_csn = ~(state_q == S_ACC || state_q == S_WAIT);
  assign sdr_as = state_q == S_ACC;
  assign sdr_nwr = nwr_q | sdr_csn;
  assign sdr_ad = ad_q;
  assign sdr_din = din_q;
  assign cpu_rdata = crd_q;
  assign dma_rdata = drd_q;
  assign cpu_rdy = ~pend_q | cpu_done;
  assign dma_ack = state_q == S_DONE && own_q == OWN_DMA;
`ifdef ARB_STATS_EN
  logic [15:0] scpu_q, scpu_d, sdma_q, sdma_d;
  logic [7:0] wcnt_q, wcnt_d, wmax_q, wmax_d;
  always_comb begin
    scpu_d = scpu_q + {15'd0, grant & ~win};
    sdma_d = sdma_q + {15'd0, grant & win};
    wcnt_d = cpu_rdy ? 8'd0 : sat_inc8(wcnt_q);
    wmax_d = cpu_done && wcnt_q > wmax_q ? wcnt_q : wmax_q;
  end
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      scpu_q <= '0;
      sdma_q <= '0;
      wcnt_q <= '0;
      wmax_q <= '0;
    end else begin
      scpu_q <= scpu_d;
      sdma_q <= sdma_d;
      wcnt_q <= wcnt_d;
      wmax_q <= wmax_d;
    end
  end
  assign stat_cpu = scpu_q;
  assign stat_dma = sdma_q;
  assign stat_maxwait = wmax_q;
`endif
endmodule
